layer_fm_buffer: RTL and testbench

// Parametrised feature-map frame buffer between CNN layers. Captures one raster frame of

---
 rtl/cnn_fm_pkg.sv | 36 +++
 rtl/fm_sdp_ram.sv | 34 +++
 rtl/layer_fm_buffer.sv | 250 +++++++++++++++++++++++++
 tb/tb_layer_fm_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_fm_pkg.sv
// ============================================================================
// Module      : cnn_fm_pkg
// Description : Shared types and sizing helpers for the layer feature-map buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cnn_fm_pkg;

  localparam int DEF_FM_WIDTH  = 4;
  localparam int DEF_FM_HEIGHT = 4;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_LINE = 2'd1,
    RD_HBLK = 2'd2,
    RD_VGAP = 2'd3
  } rd_state_e;

  function automatic int fm_depth(input int width, input int height);
    return width * height;
  endfunction

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fm_sdp_ram.sv
// ============================================================================
// Module      : fm_sdp_ram
// Description : Inferred simple dual-port RAM, one write port, registered read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fm_sdp_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/layer_fm_buffer.sv
// ============================================================================
// Module      : layer_fm_buffer
// Description : Captures one raster frame into RAM and replays it REPEAT times
//               as a regenerated vsync/href stream with programmable blanking.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module layer_fm_buffer
  import cnn_fm_pkg::*;
#(
  parameter int FM_WIDTH  = DEF_FM_WIDTH,
  parameter int FM_HEIGHT = DEF_FM_HEIGHT,
  parameter int DATA_W    = 16,
  parameter int CH        = 1,
  parameter int HBLK      = 16,
  parameter int VBLK      = 16,
  parameter int REPEAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fm_ram_wea,
  input  logic                 pre_vsync,
  input  logic                 pre_href,
  input  logic                 pre_valid,
  input  logic [CH*DATA_W-1:0] pre_data,
  input  logic                 start_output,
  output logic                 save_fm_acmp,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 post_vsync,
  output logic                 post_href,
  output logic [CH*DATA_W-1:0] post_data,
  output logic                 end_output
);

  localparam int c_FM_DEPTH = fm_depth(FM_WIDTH, FM_HEIGHT);
  localparam int c_ADDR_W   = addr_w(c_FM_DEPTH);
  localparam int c_WORD_W   = CH * DATA_W;
  localparam int c_WCNT_W   = cnt_w(c_FM_DEPTH);
  localparam int c_COL_W    = cnt_w(FM_WIDTH - 1);
  localparam int c_LINE_W   = cnt_w(FM_HEIGHT - 1);
  localparam int c_REP_W    = cnt_w(REPEAT - 1);
  localparam int c_BLK_W    = cnt_w((HBLK > VBLK) ? HBLK : VBLK);

  localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(c_FM_DEPTH - 1);
  localparam logic [c_WCNT_W-1:0] c_WCNT_FULL = c_WCNT_W'(c_FM_DEPTH);
  localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(FM_WIDTH - 1);
  localparam logic [c_LINE_W-1:0] c_LINE_LAST = c_LINE_W'(FM_HEIGHT - 1);
  localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT - 1);
  localparam logic [c_BLK_W-1:0]  c_HBLK_LAST = c_BLK_W'((HBLK > 0) ? HBLK - 1 : 0);
  localparam logic [c_BLK_W-1:0]  c_VBLK_LAST = c_BLK_W'((VBLK > 0) ? VBLK - 1 : 0);

  // ---------------------------------------------------------------- capture
  logic                r_vsync_d;
  logic [c_ADDR_W-1:0] r_wr_addr;
  logic [c_WCNT_W-1:0] r_wr_cnt;
  logic                r_frame_valid;
  logic                r_save;
  logic                r_err;

  logic                w_vs_rise;
  logic                w_vs_fall;
  logic                w_wr_en;
  logic [c_ADDR_W-1:0] w_wr_base;
  logic [c_WCNT_W-1:0] w_cnt_base;

  assign w_vs_rise  = fm_ram_wea & pre_vsync & ~r_vsync_d;
  assign w_vs_fall  = fm_ram_wea & ~pre_vsync & r_vsync_d;
  assign w_wr_en    = fm_ram_wea & pre_vsync & pre_href & pre_valid;
  // A pixel arriving on the very cycle vsync rises belongs at address 0.
  assign w_wr_base  = w_vs_rise ? '0 : r_wr_addr;
  assign w_cnt_base = w_vs_rise ? '0 : r_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_cnt      <= '0;
      r_frame_valid <= 1'b0;
      r_save        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_vsync_d <= pre_vsync;
      r_save    <= 1'b0;
      r_err     <= 1'b0;
      if (w_wr_en) begin
        r_wr_addr <= (w_wr_base == c_ADDR_LAST) ? '0 : w_wr_base + c_ADDR_W'(1);
        r_wr_cnt  <= (w_cnt_base == c_WCNT_FULL) ? w_cnt_base : w_cnt_base + c_WCNT_W'(1);
      end else begin
        r_wr_addr <= w_wr_base;
        r_wr_cnt  <= w_cnt_base;
      end
      if (w_vs_rise) r_frame_valid <= 1'b0;
      if (w_vs_fall) begin
        if (r_wr_cnt == c_WCNT_FULL) begin
          r_save        <= 1'b1;
          r_frame_valid <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- replay FSM
  rd_state_e           r_state;
  logic [c_ADDR_W-1:0] r_rd_addr;
  logic [c_COL_W-1:0]  r_col;
  logic [c_LINE_W-1:0] r_line;
  logic [c_REP_W-1:0]  r_rep;
  logic [c_BLK_W-1:0]  r_blk;

  rd_state_e           w_state_nxt;
  logic [c_ADDR_W-1:0] w_addr_nxt;
  logic [c_COL_W-1:0]  w_col_nxt;
  logic [c_LINE_W-1:0] w_line_nxt;
  logic [c_REP_W-1:0]  w_rep_nxt;
  logic [c_BLK_W-1:0]  w_blk_nxt;

  logic r_href;
  logic r_vsync;
  logic r_last_d1;
  logic r_end;

  logic w_start_ok;
  logic w_rd_en;
  logic w_fsm_vsync;
  logic w_last_pix;
  logic w_busy;

  assign w_start_ok = start_output & r_frame_valid & (r_state == RD_IDLE) & ~r_last_d1 & ~r_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RD_IDLE;
      r_rd_addr <= '0;
      r_col     <= '0;
      r_line    <= '0;
      r_rep     <= '0;
      r_blk     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_addr_nxt;
      r_col     <= w_col_nxt;
      r_line    <= w_line_nxt;
      r_rep     <= w_rep_nxt;
      r_blk     <= w_blk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_rd_addr;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line;
    w_rep_nxt   = r_rep;
    w_blk_nxt   = r_blk;
    unique case (r_state)
      RD_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = RD_LINE;
          w_addr_nxt  = '0;
          w_col_nxt   = '0;
          w_line_nxt  = '0;
          w_rep_nxt   = '0;
        end
      end
      RD_LINE: begin
        w_addr_nxt = (r_rd_addr == c_ADDR_LAST) ? '0 : r_rd_addr + c_ADDR_W'(1);
        if (r_col == c_COL_LAST) begin
          w_col_nxt = '0;
          w_blk_nxt = '0;
          if (r_line != c_LINE_LAST) begin
            w_line_nxt = r_line + c_LINE_W'(1);
            if (HBLK != 0) w_state_nxt = RD_HBLK;
          end else if (r_rep != c_REP_LAST) begin
            w_line_nxt = '0;
            w_rep_nxt  = r_rep + c_REP_W'(1);
            w_addr_nxt = '0;
            if (VBLK != 0) w_state_nxt = RD_VGAP;
          end else begin
            w_state_nxt = RD_IDLE;
          end
        end else begin
          w_col_nxt = r_col + c_COL_W'(1);
        end
      end
      RD_HBLK: begin
        if (r_blk == c_HBLK_LAST) w_state_nxt = RD_LINE;
        else                      w_blk_nxt   = r_blk + c_BLK_W'(1);
      end
      RD_VGAP: begin
        if (r_blk == c_VBLK_LAST) w_state_nxt = RD_LINE;
        else                      w_blk_nxt   = r_blk + c_BLK_W'(1);
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en     = (r_state == RD_LINE);
    w_fsm_vsync = (r_state == RD_LINE) | (r_state == RD_HBLK);
    w_last_pix  = (r_state == RD_LINE) & (r_col == c_COL_LAST) &
                  (r_line == c_LINE_LAST) & (r_rep == c_REP_LAST);
    w_busy      = (r_state != RD_IDLE) | r_last_d1 | r_end;
  end

  // Envelope is delayed one cycle to line up with the registered RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_href    <= 1'b0;
      r_vsync   <= 1'b0;
      r_last_d1 <= 1'b0;
      r_end     <= 1'b0;
    end else begin
      r_href    <= w_rd_en;
      r_vsync   <= w_fsm_vsync;
      r_last_d1 <= w_last_pix;
      r_end     <= r_last_d1;
    end
  end

  logic [c_WORD_W-1:0] w_ram_q;

  fm_sdp_ram #(
    .DEPTH  (c_FM_DEPTH),
    .WIDTH  (c_WORD_W),
    .ADDR_W (c_ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_base),
    .i_wr_data (pre_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_ram_q)
  );

  assign save_fm_acmp = r_save;
  assign frame_err    = r_err;
  assign busy         = w_busy;
  assign post_vsync   = r_vsync;
  assign post_href    = r_href;
  assign post_data    = r_href ? w_ram_q : '0;
  assign end_output   = r_end;

endmodule

`default_nettype wire

// File: tb/tb_layer_fm_buffer.sv
// ============================================================================
// Module      : tb_layer_fm_buffer
// Description : Self-checking bench; three buffer configurations share stimulus.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_layer_fm_buffer;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int DW    = 8;
  localparam int CHN   = 2;
  localparam int DEPTH = W * H;
  localparam int ND    = 3;
  localparam int NCYC  = 212;

  function automatic int hb_of(input int k);
    return (k == 2) ? 0 : 16;
  endfunction
  function automatic int vb_of(input int k);
    return (k == 1) ? 5 : 16;
  endfunction
  function automatic int rp_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic [15:0] d;
    logic        bz;
    logic        en;
  } obs_t;

  function automatic obs_t mk(input logic vs, input logic hr, input logic [15:0] d,
                              input logic bz, input logic en);
    obs_t o;
    o.vs = vs; o.hr = hr; o.d = d; o.bz = bz; o.en = en;
    return o;
  endfunction

  logic        clk;
  logic        rst;
  logic        wea;
  logic        pvs;
  logic        phr;
  logic        pval;
  logic [15:0] pdat;
  logic        start;

  logic        save [ND];
  logic        err  [ND];
  logic        bsy  [ND];
  logic        vs   [ND];
  logic        hr   [ND];
  logic [15:0] pd   [ND];
  logic        endo [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    layer_fm_buffer #(
      .FM_WIDTH (W),
      .FM_HEIGHT(H),
      .DATA_W   (DW),
      .CH       (CHN),
      .HBLK     (hb_of(g)),
      .VBLK     (vb_of(g)),
      .REPEAT   (rp_of(g))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .fm_ram_wea   (wea),
      .pre_vsync    (pvs),
      .pre_href     (phr),
      .pre_valid    (pval),
      .pre_data     (pdat),
      .start_output (start),
      .save_fm_acmp (save[g]),
      .frame_err    (err[g]),
      .busy         (bsy[g]),
      .post_vsync   (vs[g]),
      .post_href    (hr[g]),
      .post_data    (pd[g]),
      .end_output   (endo[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int save_cnt [ND];
  int err_cnt  [ND];
  initial for (int k = 0; k < ND; k++) begin save_cnt[k] = 0; err_cnt[k] = 0; end
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (save[k] === 1'b1) save_cnt[k] = save_cnt[k] + 1;
      if (err[k]  === 1'b1) err_cnt[k]  = err_cnt[k] + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_mem [DEPTH];
  bit          ref_fv = 0;
  int          wp = 0;
  obs_t        exp_q [ND][$];

  // Expected replay stream, index 0 = the cycle after start_output is sampled.
  task automatic build_exp(input int k);
    exp_q[k].delete();
    if (!ref_fv) return;
    exp_q[k].push_back(mk(0, 0, 16'h0, 1, 0));
    for (int rp = 0; rp < rp_of(k); rp++) begin
      for (int ln = 0; ln < H; ln++) begin
        for (int c = 0; c < W; c++) exp_q[k].push_back(mk(1, 1, ref_mem[ln*W + c], 1, 0));
        if (ln < H - 1) for (int b = 0; b < hb_of(k); b++) exp_q[k].push_back(mk(1, 0, 16'h0, 1, 0));
      end
      if (rp < rp_of(k) - 1) for (int b = 0; b < vb_of(k); b++) exp_q[k].push_back(mk(0, 0, 16'h0, 1, 0));
    end
    exp_q[k].push_back(mk(0, 0, 16'h0, 1, 1));
  endtask

  task automatic test_reset;
    rst = 1; wea = 0; pvs = 0; phr = 0; pval = 0; pdat = '0; start = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      obs_t got;
      got = mk(vs[k], hr[k], pd[k], bsy[k], endo[k]);
      checks++;
      if (got !== mk(0, 0, 16'h0, 0, 0) || save[k] !== 1'b0 || err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d got=%h save=%b err=%b expected all zero", k, got, save[k], err[k]);
      end
    end
  endtask

  task automatic test_frame(input string name, input int n, input bit we, input bit seq);
    int s0 [ND];
    int e0 [ND];
    int i;
    for (int k = 0; k < ND; k++) begin s0[k] = save_cnt[k]; e0[k] = err_cnt[k]; end
    @(negedge clk);
    wea = we; pvs = 1; phr = 0; pval = 0;
    if (we) begin ref_fv = 0; wp = 0; end
    @(negedge clk);
    i = 0;
    while (i < n) begin
      phr = 1;
      for (int c = 0; c < W && i < n; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          pval = 0; pdat = 16'($urandom);
          @(negedge clk);
        end
        pval = 1;
        pdat = seq ? 16'(i) : 16'($urandom);
        if (we) begin ref_mem[wp] = pdat; wp = (wp + 1) % DEPTH; end
        i++;
        @(negedge clk);
      end
      pval = 0; phr = 0;
      repeat (2) @(negedge clk);
    end
    pvs = 0;
    repeat (4) @(negedge clk);
    wea = 0;
    if (we) ref_fv = (n == DEPTH);
    for (int k = 0; k < ND; k++) begin
      int es;
      int ee;
      es = (we && n == DEPTH) ? 1 : 0;
      ee = (we && n != DEPTH) ? 1 : 0;
      checks++;
      if (save_cnt[k] - s0[k] != es) begin
        errors++;
        $display("FAIL %s save dut%0d got=%0d expected=%0d", name, k, save_cnt[k] - s0[k], es);
      end
      checks++;
      if (err_cnt[k] - e0[k] != ee) begin
        errors++;
        $display("FAIL %s err dut%0d got=%0d expected=%0d", name, k, err_cnt[k] - e0[k], ee);
      end
    end
  endtask

  // A second start_output is pulsed mid-replay; it must have no effect.
  task automatic test_replay(input string name);
    for (int k = 0; k < ND; k++) build_exp(k);
    @(negedge clk);
    start = 1;
    for (int idx = 0; idx < NCYC; idx++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        obs_t got;
        obs_t e;
        got = mk(vs[k], hr[k], pd[k], bsy[k], endo[k]);
        e   = (idx < exp_q[k].size()) ? exp_q[k][idx] : mk(0, 0, 16'h0, 0, 0);
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s dut%0d idx%0d got vs=%b hr=%b d=%h busy=%b end=%b expected vs=%b hr=%b d=%h busy=%b end=%b",
                   name, k, idx, got.vs, got.hr, got.d, got.bz, got.en, e.vs, e.hr, e.d, e.bz, e.en);
        end
      end
      start = (idx == 5);
    end
    start = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    ref_fv = 0;
    wp = 0;
    for (int k = 0; k < ND; k++) begin
      obs_t got;
      got = mk(vs[k], hr[k], pd[k], bsy[k], endo[k]);
      checks++;
      if (got !== mk(0, 0, 16'h0, 0, 0) || save[k] !== 1'b0 || err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d got=%h save=%b err=%b expected all zero", k, got, save[k], err[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame("cap_seq", DEPTH, 1'b1, 1'b1);
    test_replay("replay_seq");
    test_frame("short", DEPTH - 1, 1'b1, 1'b0);
    test_replay("ignored");
    test_frame("cap_rand", DEPTH, 1'b1, 1'b0);
    test_frame("no_wea", DEPTH, 1'b0, 1'b0);
    test_replay("replay_kept");
    test_reset_mid();
    test_replay("after_rst");
    test_frame("recover", DEPTH, 1'b1, 1'b0);
    test_replay("recover");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
